// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// The sequencer drives the master side; the ALU sits on the slave side.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_hi;
   logic             carry;
   logic             zero;
   logic             dz_err;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, out, out_hi, carry, zero, dz_err
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, out, out_hi, carry, zero, dz_err
   );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides.
// MUL is shift-add and DIV is restoring divide, one step per cycle; every
// other op finishes in the single cycle after accept.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
                          OP_INC = 4'h4, OP_DEC = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                          OP_NOT = 4'h8, OP_NAND = 4'h9, OP_NOR = 4'hA, OP_XOR = 4'hB,
                          OP_XNOR = 4'hC, OP_GT = 4'hD, OP_LT = 4'hE, OP_EQ = 4'hF;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ra, rb, hi, lo;
   logic [3:0]       rsel;

   logic [WIDTH:0]   msum, dsh, ddiff, t;
   logic [WIDTH-1:0] hi_nx, lo_nx;
   logic [WIDTH-1:0] res, res_hi;
   logic             res_c, res_dz;

   // One iterative step: {hi,lo} is the product accumulator for MUL and the
   // {remainder,quotient} pair for DIV.
   always_comb begin
      msum  = {1'b0, hi} + (lo[0] ? {1'b0, rb} : '0);
      dsh   = {hi, lo[WIDTH-1]};
      ddiff = dsh - {1'b0, rb};
      hi_nx = hi;
      lo_nx = lo;
      if (rsel == OP_MUL) begin
         hi_nx = msum[WIDTH:1];
         lo_nx = {msum[0], lo[WIDTH-1:1]};
      end else if (dsh >= {1'b0, rb}) begin
         hi_nx = ddiff[WIDTH-1:0];
         lo_nx = {lo[WIDTH-2:0], 1'b1};
      end else begin
         hi_nx = dsh[WIDTH-1:0];
         lo_nx = {lo[WIDTH-2:0], 1'b0};
      end
   end

   // Final result from the captured operands (or the finished accumulator).
   always_comb begin
      t      = '0;
      res    = '0;
      res_hi = '0;
      res_c  = 1'b0;
      res_dz = 1'b0;
      case (rsel)
         OP_ADD:  t = {1'b0, ra} + {1'b0, rb};
         OP_SUB:  t = {1'b0, ra} - {1'b0, rb};
         OP_INC:  t = {1'b0, ra} + (WIDTH+1)'(1);
         OP_DEC:  t = {1'b0, ra} - (WIDTH+1)'(1);
         default: t = '0;
      endcase
      case (rsel)
         OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            res   = t[WIDTH-1:0];
            res_c = t[WIDTH];
         end
         OP_MUL: begin
            res    = lo;
            res_hi = hi;
         end
         OP_DIV: begin
            if (rb == '0) begin
               res    = '1;
               res_hi = ra;
               res_dz = 1'b1;
            end else begin
               res    = lo;
               res_hi = hi;
            end
         end
         OP_AND:  res = ra & rb;
         OP_OR:   res = ra | rb;
         OP_NOT:  res = ~ra;
         OP_NAND: res = ~(ra & rb);
         OP_NOR:  res = ~(ra | rb);
         OP_XOR:  res = ra ^ rb;
         OP_XNOR: res = ~(ra ^ rb);
         OP_GT:   res = {{(WIDTH-1){1'b0}}, ra > rb};
         OP_LT:   res = {{(WIDTH-1){1'b0}}, ra < rb};
         OP_EQ:   res = {{(WIDTH-1){1'b0}}, ra == rb};
         default: res = '0;
      endcase
   end

   // Control FSM with registered handshake and result outputs. Single-cycle
   // ops enter BUSY with cnt=0 so the result is written one edge after
   // accept; MUL/DIV run WIDTH steps first, then write on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         ra            <= '0;
         rb            <= '0;
         rsel          <= '0;
         hi            <= '0;
         lo            <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out       <= '0;
         bus.out_hi    <= '0;
         bus.carry     <= 1'b0;
         bus.zero      <= 1'b0;
         bus.dz_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  ra           <= bus.a;
                  rb           <= bus.b;
                  rsel         <= bus.sel;
                  hi           <= '0;
                  lo           <= bus.a;
                  bus.in_ready <= 1'b0;
                  cnt          <= ((bus.sel == OP_MUL) || (bus.sel == OP_DIV && bus.b != '0))
                                  ? CW'(WIDTH) : '0;
                  state        <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  bus.out       <= res;
                  bus.out_hi    <= res_hi;
                  bus.carry     <= res_c;
                  bus.zero      <= (res == '0);
                  bus.dz_err    <= res_dz;
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end else begin
                  hi  <= hi_nx;
                  lo  <= lo_nx;
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq (WIDTH=16) against an
// arithmetic reference model.
module tb_alu_seq;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W)) bus();
   alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [W-1:0] o;
      logic [W-1:0] h;
      logic         c;
      logic         z;
      logic         dz;
      int           lat;
   } exp_t;

   // Reference: plain integer arithmetic on the opcode map.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
      exp_t r;
      longint ua, ub, full, t;
      ua = longint'(a); ub = longint'(b); full = longint'(1) << W;
      r.o = '0; r.h = '0; r.c = 1'b0; r.dz = 1'b0; r.lat = 1;
      case (s)
         4'h0: begin t = ua + ub; r.o = W'(t % full); r.c = (t >= full); end
         4'h1: begin r.o = W'((ua - ub + full) % full); r.c = (ua < ub); end
         4'h2: begin t = ua * ub; r.o = W'(t % full); r.h = W'(t / full); r.lat = W + 1; end
         4'h3: begin
            if (ub == 0) begin r.o = W'(full - 1); r.h = a; r.dz = 1'b1; end
            else begin r.o = W'(ua / ub); r.h = W'(ua % ub); r.lat = W + 1; end
         end
         4'h4: begin t = ua + 1; r.o = W'(t % full); r.c = (t >= full); end
         4'h5: begin r.o = W'((ua - 1 + full) % full); r.c = (ua == 0); end
         4'h6: r.o = a & b;
         4'h7: r.o = a | b;
         4'h8: r.o = ~a;
         4'h9: r.o = ~(a & b);
         4'hA: r.o = ~(a | b);
         4'hB: r.o = a ^ b;
         4'hC: r.o = ~(a ^ b);
         4'hD: r.o = (ua > ub) ? W'(1) : W'(0);
         4'hE: r.o = (ua < ub) ? W'(1) : W'(0);
         default: r.o = (ua == ub) ? W'(1) : W'(0);
      endcase
      r.z = (r.o == '0);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one op, wait for the result, optionally stall (with a competing
   // in_valid held high) and then accept it.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] s, input int stall, input bit garb);
      exp_t e;
      int   n, lat;
      e = model(a, b, s);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.sel = s; bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk({tag, "_accept_timeout"}, 0, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.sel = 4'($urandom);
      lat = 0;
      do begin
         @(posedge clk); lat++; @(negedge clk);
      end while (!bus.out_valid && lat < 200);
      chk({tag, "_lat"},    lat,          e.lat);
      chk({tag, "_out"},    bus.out,      e.o);
      chk({tag, "_hi"},     bus.out_hi,   e.h);
      chk({tag, "_carry"},  bus.carry,    e.c);
      chk({tag, "_zero"},   bus.zero,     e.z);
      chk({tag, "_dz"},     bus.dz_err,   e.dz);
      chk({tag, "_inrdy"},  bus.in_ready, 0);
      for (int i = 0; i < stall; i++) begin
         if (garb) begin
            bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom); bus.sel = 4'($urandom);
         end
         @(posedge clk); @(negedge clk);
         chk({tag, "_hold_vld"}, bus.out_valid, 1);
         chk({tag, "_hold_out"}, {bus.out_hi, bus.out, bus.carry}, {e.h, e.o, e.c});
         chk({tag, "_hold_rdy"}, bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk({tag, "_drain"}, {bus.out_valid, bus.in_ready}, 2'b01);
   endtask

   initial begin
      exp_t e;
      logic [3:0] s;
      logic [W-1:0] ra, rb;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.sel = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {bus.out_valid, bus.out, bus.out_hi, bus.carry, bus.zero, bus.dz_err}, '0);
      chk("reset_inrdy", bus.in_ready, 1);
      rst_n = 1'b1;

      run_op("add_wrap", 16'hFFFF, 16'h0001, 4'h0, 0, 1'b0);
      run_op("mul",      16'h1234, 16'h0100, 4'h2, 0, 1'b0);
      run_op("div",      16'h0064, 16'h0007, 4'h3, 0, 1'b0);
      run_op("div0",     16'h00AB, 16'h0000, 4'h3, 0, 1'b0);
      run_op("sub_hold", 16'h0001, 16'h0002, 4'h1, 5, 1'b1);
      run_op("dec0",     16'h0000, 16'h0000, 4'h5, 0, 1'b0);
      run_op("inc_max",  16'hFFFF, 16'h0000, 4'h4, 0, 1'b0);
      run_op("mul_max",  16'hFFFF, 16'hFFFF, 4'h2, 0, 1'b0);
      run_op("eq",       16'h5A5A, 16'h5A5A, 4'hF, 0, 1'b0);

      // Reset in the middle of a multiply.
      @(negedge clk);
      bus.a = 16'h1234; bus.b = 16'h0100; bus.sel = 4'h2; bus.in_valid = 1'b1;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_outs", {bus.out_valid, bus.out, bus.out_hi, bus.carry, bus.zero, bus.dz_err}, '0);
      chk("midrst_inrdy", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("add_after_rst", 16'h0003, 16'h0004, 4'h0, 0, 1'b0);

      // Random back-to-back ops with random backpressure.
      for (int i = 0; i < 100; i++) begin
         s  = 4'($urandom);
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 3) == 0) rb = '0;
         run_op($sformatf("rnd%0d_op%0h", i, s), ra, rb, s, $urandom_range(0, 3), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
